alu_design: RTL and testbench

- Parameterised, registered integer ALU with separate arithmetic and logical command sets, selected by MODE.
- Sits behind the ALU bus interface (alu_intf); a coverage monitor (cover_age) samples its inputs and RES.
- Operands are qualified per cycle by CE and INP_VALID; results and flags are registered one clock after capture.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_design_if.sv | 32 +++
 rtl/alu_rotate.sv | 25 ++
 rtl/alu_design.sv | 156 +++++++++++++++
 tb/tb_alu_design.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, operand-valid and sizing definitions for the ALU
package alu_pkg;

    localparam int DEFAULT_N  = 8;
    localparam int DEFAULT_CW = 4;

    // Arithmetic command set (MODE=1)
    localparam logic [3:0] ADD     = 4'd0;
    localparam logic [3:0] SUB     = 4'd1;
    localparam logic [3:0] ADD_CIN = 4'd2;
    localparam logic [3:0] SUB_CIN = 4'd3;
    localparam logic [3:0] INC_A   = 4'd4;
    localparam logic [3:0] DEC_A   = 4'd5;
    localparam logic [3:0] INC_B   = 4'd6;
    localparam logic [3:0] DEC_B   = 4'd7;
    localparam logic [3:0] CMP     = 4'd8;
    localparam logic [3:0] INC_MUL = 4'd9;
    localparam logic [3:0] SHL_MUL = 4'd10;

    // Logical command set (MODE=0)
    localparam logic [3:0] AND     = 4'd0;
    localparam logic [3:0] NAND    = 4'd1;
    localparam logic [3:0] OR      = 4'd2;
    localparam logic [3:0] NOR     = 4'd3;
    localparam logic [3:0] XOR     = 4'd4;
    localparam logic [3:0] XNOR    = 4'd5;
    localparam logic [3:0] NOT_A   = 4'd6;
    localparam logic [3:0] NOT_B   = 4'd7;
    localparam logic [3:0] SHR1_A  = 4'd8;
    localparam logic [3:0] SHL1_A  = 4'd9;
    localparam logic [3:0] SHR1_B  = 4'd10;
    localparam logic [3:0] SHL1_B  = 4'd11;
    localparam logic [3:0] ROL_A_B = 4'd12;
    localparam logic [3:0] ROR_A_B = 4'd13;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        A_ONLY = 2'b01,
        B_ONLY = 2'b10,
        BOTH   = 2'b11
    } inp_valid_e;

endpackage

// File: rtl/alu_design_if.sv
// rtl/alu_design_if.sv - ALU bus interface (alu_intf) grouping operands, command and result flags
interface alu_intf
    import alu_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = DEFAULT_CW
);
    logic [N-1:0]   OPA;
    logic [N-1:0]   OPB;
    logic           CIN;
    logic           CE;
    logic           MODE;
    logic [CW-1:0]  CMD;
    logic [1:0]     INP_VALID;
    logic [2*N-1:0] RES;
    logic           COUT;
    logic           OFLOW;
    logic           G;
    logic           L;
    logic           E;
    logic           ERR;

    modport master (
        output OPA, OPB, CIN, CE, MODE, CMD, INP_VALID,
        input  RES, COUT, OFLOW, G, L, E, ERR
    );

    modport slave (
        input  OPA, OPB, CIN, CE, MODE, CMD, INP_VALID,
        output RES, COUT, OFLOW, G, L, E, ERR
    );
endinterface

// File: rtl/alu_rotate.sv
// rtl/alu_rotate.sv - combinational rotate of A by the low log2(N) bits of the amount, with range check
module alu_rotate #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] amt,
    input  logic         left,
    output logic [N-1:0] res,
    output logic         range_err
);
    localparam int SW = $clog2(N);

    logic [SW-1:0]  sh;
    logic [2*N-1:0] l_ext;
    logic [2*N-1:0] r_ext;

    // Shifting a doubled copy yields the rotation in one half without wrap logic.
    always_comb begin
        sh        = amt[SW-1:0];
        l_ext     = {a, a} << sh;
        r_ext     = {a, a} >> sh;
        res       = left ? l_ext[2*N-1:N] : r_ext[N-1:0];
        range_err = |amt[N-1:SW];
    end
endmodule

// File: rtl/alu_design.sv
// rtl/alu_design.sv - registered arithmetic/logical ALU; define MUL_EN to include commands 9 and 10
module alu_design
    import alu_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = DEFAULT_CW
) (
    input logic     CLK,
    input logic     RST,
    alu_intf.slave  bus
);
    logic [2*N-1:0] res_d, res_q;
    logic           cout_d, cout_q, oflow_d, oflow_q;
    logic           g_d, g_q, l_d, l_q, e_d, e_q, err_d, err_q;

    logic [3:0]   op;
    logic         op_ok, need_a, need_b, a_ok, b_ok, cmd_err;
    logic [N:0]   a_x, b_x, c_x, sum;
    logic [N-1:0] lres, rot_res;
    logic         rot_err;
`ifdef MUL_EN
    logic [2*N-1:0] a_w, b_w, a_shl_w;
`endif

    alu_rotate #(.N(N)) u_rotate (
        .a         (bus.OPA),
        .amt       (bus.OPB),
        .left      (op == ROL_A_B),
        .res       (rot_res),
        .range_err (rot_err)
    );

    always_comb begin
        op     = 4'(bus.CMD);
        op_ok  = (CW'(op) == bus.CMD);
        need_a = 1'b0;
        need_b = 1'b0;
        if (bus.MODE) begin
            case (op)
                ADD, SUB, ADD_CIN, SUB_CIN, CMP: begin need_a = 1'b1; need_b = 1'b1; end
                INC_A, DEC_A:                    need_a = 1'b1;
                INC_B, DEC_B:                    need_b = 1'b1;
`ifdef MUL_EN
                INC_MUL, SHL_MUL:                begin need_a = 1'b1; need_b = 1'b1; end
`endif
                default:                         op_ok = 1'b0;
            endcase
        end else begin
            case (op)
                AND, NAND, OR, NOR, XOR, XNOR, ROL_A_B, ROR_A_B: begin need_a = 1'b1; need_b = 1'b1; end
                NOT_A, SHR1_A, SHL1_A:                           need_a = 1'b1;
                NOT_B, SHR1_B, SHL1_B:                           need_b = 1'b1;
                default:                                         op_ok = 1'b0;
            endcase
        end
        a_ok    = (bus.INP_VALID & 2'(A_ONLY)) != 2'(NONE);
        b_ok    = (bus.INP_VALID & 2'(B_ONLY)) != 2'(NONE);
        cmd_err = !op_ok || (need_a && !a_ok) || (need_b && !b_ok);
    end

    always_comb begin
        res_d   = res_q;
        cout_d  = cout_q;
        oflow_d = oflow_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        err_d   = err_q;
        a_x     = {1'b0, bus.OPA};
        b_x     = {1'b0, bus.OPB};
        c_x     = {{N{1'b0}}, bus.CIN};
        sum     = '0;
        lres    = '0;
`ifdef MUL_EN
        a_w     = {{N{1'b0}}, bus.OPA};
        b_w     = {{N{1'b0}}, bus.OPB};
        a_shl_w = {{N{1'b0}}, bus.OPA << 1};
`endif
        if (bus.CE) begin
            res_d   = '0;
            cout_d  = 1'b0;
            oflow_d = 1'b0;
            g_d     = 1'b0;
            l_d     = 1'b0;
            e_d     = 1'b0;
            err_d   = 1'b0;
            if (cmd_err) begin
                err_d = 1'b1;
            end else if (bus.MODE) begin
                case (op)
                    ADD:     begin sum = a_x + b_x;       cout_d  = sum[N]; end
                    SUB:     begin sum = a_x - b_x;       oflow_d = a_x < b_x; end
                    ADD_CIN: begin sum = a_x + b_x + c_x; cout_d  = sum[N]; end
                    SUB_CIN: begin sum = a_x - b_x - c_x; oflow_d = a_x < (b_x + c_x); end
                    INC_A:   begin sum = a_x + 1'b1;      cout_d  = sum[N]; end
                    DEC_A:   begin sum = a_x - 1'b1;      oflow_d = (bus.OPA == '0); end
                    INC_B:   begin sum = b_x + 1'b1;      cout_d  = sum[N]; end
                    DEC_B:   begin sum = b_x - 1'b1;      oflow_d = (bus.OPB == '0); end
                    CMP:     begin g_d = a_x > b_x; l_d = a_x < b_x; e_d = a_x == b_x; end
                    default: ;
                endcase
                res_d = {{(N-1){1'b0}}, sum};
`ifdef MUL_EN
                if (op == INC_MUL) res_d = (a_w + (2*N)'(1)) * (b_w + (2*N)'(1));
                if (op == SHL_MUL) res_d = a_shl_w * b_w;
`endif
            end else begin
                case (op)
                    AND:     lres = bus.OPA & bus.OPB;
                    NAND:    lres = ~(bus.OPA & bus.OPB);
                    OR:      lres = bus.OPA | bus.OPB;
                    NOR:     lres = ~(bus.OPA | bus.OPB);
                    XOR:     lres = bus.OPA ^ bus.OPB;
                    XNOR:    lres = ~(bus.OPA ^ bus.OPB);
                    NOT_A:   lres = ~bus.OPA;
                    NOT_B:   lres = ~bus.OPB;
                    SHR1_A:  lres = bus.OPA >> 1;
                    SHL1_A:  lres = bus.OPA << 1;
                    SHR1_B:  lres = bus.OPB >> 1;
                    SHL1_B:  lres = bus.OPB << 1;
                    ROL_A_B, ROR_A_B: begin lres = rot_res; err_d = rot_err; end
                    default: ;
                endcase
                res_d = {{N{1'b0}}, lres};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            err_q   <= err_d;
        end
    end

    assign bus.RES   = res_q;
    assign bus.COUT  = cout_q;
    assign bus.OFLOW = oflow_q;
    assign bus.G     = g_q;
    assign bus.L     = l_q;
    assign bus.E     = e_q;
    assign bus.ERR   = err_q;
endmodule

// File: tb/tb_alu_design.sv
// tb/tb_alu_design.sv - self-checking bench for alu_design against a behavioural reference model
module tb_alu_design;
    localparam int N  = 8;
    localparam int CW = 4;
`ifdef MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    typedef struct packed {
        logic [2*N-1:0] res;
        logic cout, oflow, g, l, e, err;
    } out_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;
    out_t exp_q = '0;

    alu_intf #(.N(N), .CW(CW)) bus ();
    alu_design #(.N(N), .CW(CW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    function automatic out_t model(input bit mode, input int cmd, input int a, input int b,
                                   input bit cin, input bit [1:0] iv);
        out_t o;
        int   need;
        int   r;
        int   sh;
        o = '0;
        r = 0;
        if (mode) begin
            case (cmd)
                0, 1, 2, 3, 8: need = 3;
                4, 5:          need = 1;
                6, 7:          need = 2;
                9, 10:         need = MUL ? 3 : 0;
                default:       need = 0;
            endcase
        end else begin
            case (cmd)
                0, 1, 2, 3, 4, 5, 12, 13: need = 3;
                6, 8, 9:                  need = 1;
                7, 10, 11:                need = 2;
                default:                  need = 0;
            endcase
        end
        if (need == 0 || (int'(iv) & need) != need) begin
            o.err = 1'b1;
            return o;
        end
        if (mode) begin
            case (cmd)
                0:  begin r = a + b;                   o.cout  = r > 255; end
                1:  begin r = (a - b) & 'h1FF;         o.oflow = a < b; end
                2:  begin r = a + b + int'(cin);       o.cout  = r > 255; end
                3:  begin r = (a - b - int'(cin)) & 'h1FF; o.oflow = a < b + int'(cin); end
                4:  begin r = a + 1;                   o.cout  = r > 255; end
                5:  begin r = (a - 1) & 'h1FF;         o.oflow = a == 0; end
                6:  begin r = b + 1;                   o.cout  = r > 255; end
                7:  begin r = (b - 1) & 'h1FF;         o.oflow = b == 0; end
                8:  begin o.g = a > b; o.l = a < b; o.e = a == b; end
                9:  r = ((a + 1) * (b + 1)) & 'hFFFF;
                10: r = ((a * 2) & 255) * b;
                default: ;
            endcase
        end else begin
            sh = b % 8;
            case (cmd)
                0:  r = a & b;
                1:  r = ~(a & b) & 255;
                2:  r = a | b;
                3:  r = ~(a | b) & 255;
                4:  r = a ^ b;
                5:  r = ~(a ^ b) & 255;
                6:  r = ~a & 255;
                7:  r = ~b & 255;
                8:  r = a / 2;
                9:  r = (a * 2) & 255;
                10: r = b / 2;
                11: r = (b * 2) & 255;
                12: begin r = ((a << sh) | (a >> (8 - sh))) & 255; o.err = b >= 8; end
                13: begin r = ((a >> sh) | (a << (8 - sh))) & 255; o.err = b >= 8; end
                default: ;
            endcase
        end
        o.res = r[15:0];
        return o;
    endfunction

    task automatic check(input string tag, input out_t e);
        out_t o;
        o = {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.L, bus.E, bus.ERR};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input bit ce, input bit mode, input int cmd,
                        input int a, input int b, input bit cin, input bit [1:0] iv);
        @(negedge CLK);
        bus.CE        = ce;
        bus.MODE      = mode;
        bus.CMD       = 4'(cmd);
        bus.OPA       = 8'(a);
        bus.OPB       = 8'(b);
        bus.CIN       = cin;
        bus.INP_VALID = iv;
        @(posedge CLK);
        #1;
        if (ce) exp_q = model(mode, cmd, a, b, cin, iv);
        check(tag, exp_q);
    endtask

    initial begin
        bus.CE = 1'b0; bus.MODE = 1'b0; bus.CMD = '0; bus.OPA = '0; bus.OPB = '0;
        bus.CIN = 1'b0; bus.INP_VALID = 2'b00;
        @(posedge CLK); #1;
        check("reset_state", '0);
        @(negedge CLK); RST = 1'b0;
        step("idle_after_reset", 0, 1, 0, 'hFF, 'h01, 0, 2'b11);
        check("idle_after_reset_k", '0);

        step("add_ff_01", 1, 1, 0, 'hFF, 'h01, 0, 2'b11);
        check("add_ff_01_k", out_t'({16'h0100, 6'b100000}));
        step("sub_cin", 1, 1, 3, 'h03, 'h05, 1, 2'b11);
        check("sub_cin_k", out_t'({16'h01FD, 6'b010000}));
        step("sub_3_5", 1, 1, 1, 'h03, 'h05, 0, 2'b11);
        check("sub_3_5_k", out_t'({16'h01FE, 6'b010000}));
        step("cmp_eq", 1, 1, 8, 'h5A, 'h5A, 0, 2'b11);
        check("cmp_eq_k", out_t'({16'h0000, 6'b000010}));
        step("inc_mul", 1, 1, 9, 'h02, 'h03, 0, 2'b11);
        check("inc_mul_k", MUL ? out_t'({16'h000C, 6'b000000}) : out_t'({16'h0000, 6'b000001}));
        step("dec_a_zero", 1, 1, 5, 'h00, 'h33, 0, 2'b01);
        step("inc_b_wrap", 1, 1, 6, 'h12, 'hFF, 0, 2'b10);
        step("arith_bad_cmd", 1, 1, 11, 'h12, 'h34, 0, 2'b11);
        step("rol_ok", 1, 0, 12, 'h81, 'h01, 0, 2'b11);
        check("rol_ok_k", out_t'({16'h0003, 6'b000000}));
        step("rol_range", 1, 0, 12, 'h81, 'h11, 0, 2'b11);
        check("rol_range_k", out_t'({16'h0003, 6'b000001}));
        step("and_a_only", 1, 0, 0, 'h3C, 'h0F, 0, 2'b01);
        check("and_a_only_k", out_t'({16'h0000, 6'b000001}));
        step("not_a", 1, 0, 6, 'h0F, 'h00, 0, 2'b01);
        check("not_a_k", out_t'({16'h00F0, 6'b000000}));
        step("iv_none", 1, 0, 6, 'h0F, 'h00, 0, 2'b00);
        step("logic_bad_cmd", 1, 0, 15, 'h0F, 'h00, 0, 2'b11);

        step("pre_hold", 1, 1, 0, 'h40, 'h41, 0, 2'b11);
        for (int i = 0; i < 3; i++)
            step("ce_hold", 0, i[0], i + 1, $urandom_range(0, 255), $urandom_range(0, 255), 1, 2'b11);

        @(negedge CLK); #2;
        RST = 1'b1;
        #1;
        exp_q = '0;
        check("rst_async", exp_q);
        bus.CE = 1'b1; bus.MODE = 1'b1; bus.CMD = 4'd0; bus.INP_VALID = 2'b11;
        @(posedge CLK); #1;
        check("rst_held", exp_q);
        @(negedge CLK); RST = 1'b0;

        for (int i = 0; i < 400; i++) begin
            bit [1:0] iv;
            iv = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            step("random", $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15), $urandom_range(0, 255),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7),
                 1'($urandom_range(0, 1)), iv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
